// File: rtl/hms_pkg.sv
// Shared widths, default moduli and direction type for the time-of-day counter.
package hms_pkg;

   localparam int unsigned SEC_W       = 6;
   localparam int unsigned MIN_W       = 6;
   localparam int unsigned SEC_MOD_DEF = 60;
   localparam int unsigned MIN_MOD_DEF = 60;
   localparam int unsigned HR_MOD_DEF  = 24;
   localparam int unsigned HR_W_DEF    = 5;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // True when an hr_w-bit field can hold every value below hr_mod.
   function automatic logic hr_w_fits(input int unsigned hr_w, input int unsigned hr_mod);
      return (64'(1) << hr_w) >= 64'(hr_mod);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// One modulo-MOD up/down stage with load and a combinational carry/borrow.
module mod_counter
   import hms_pkg::*;
#(
   parameter int unsigned MOD = 60,
   parameter int unsigned W   = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   input  dir_e         dir,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         wrap_c
);

   // Widened by one bit so MOD == 2^W does not collapse to zero.
   localparam logic [W:0]   MOD_X = (W+1)'(MOD);
   localparam logic [W-1:0] MAX_V = W'(MOD - 1);

   logic [W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      wrap_c  = 1'b0;
      if (load) begin
         value_d = load_val;
      end else if ({1'b0, value_q} >= MOD_X) begin
         value_d = '0;
      end else if (step) begin
         if (dir == DIR_UP) begin
            if (value_q == MAX_V) begin
               value_d = '0;
               wrap_c  = 1'b1;
            end else begin
               value_d = value_q + W'(1);
            end
         end else begin
            if (value_q == '0) begin
               value_d = MAX_V;
               wrap_c  = 1'b1;
            end else begin
               value_d = value_q - W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value_q <= '0;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/hms_time_counter.sv
// Cascaded seconds/minutes/hours counter with range-checked load and wrap ticks.
module hms_time_counter
   import hms_pkg::*;
#(
   parameter int unsigned SEC_MOD = SEC_MOD_DEF,
   parameter int unsigned MIN_MOD = MIN_MOD_DEF,
   parameter int unsigned HR_MOD  = HR_MOD_DEF,
   parameter int unsigned HR_W    = HR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             count_down,
   input  logic             load,
   input  logic [SEC_W-1:0] load_sec,
   input  logic [MIN_W-1:0] load_min,
   input  logic [HR_W-1:0]  load_hr,
   output logic [SEC_W-1:0] seconds,
   output logic [MIN_W-1:0] minutes,
   output logic [HR_W-1:0]  hours,
   output logic             tick_minute,
   output logic             tick_hour,
   output logic             tick_day,
   output logic             load_err
);

   if (!hr_w_fits(HR_W, HR_MOD)) begin : g_hr_w_check
      $error("HR_W too narrow for HR_MOD");
   end

   logic load_ok_c, step_c;
   logic sec_wrap_c, min_wrap_c, hr_wrap_c;
   dir_e dir_c;
   logic tick_minute_q, tick_hour_q, tick_day_q, load_err_q;
   logic tick_minute_d, tick_hour_d, tick_day_d, load_err_d;

   // Any load request, accepted or not, suppresses the enable step.
   always_comb begin
      load_ok_c = load
                  && ({1'b0, load_sec} < (SEC_W+1)'(SEC_MOD))
                  && ({1'b0, load_min} < (MIN_W+1)'(MIN_MOD))
                  && ({1'b0, load_hr}  < (HR_W+1)'(HR_MOD));
      step_c    = enable && !load;
      dir_c     = dir_e'(count_down);
   end

   mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
      .clk(clk), .rst_n(rst_n), .step(step_c), .dir(dir_c),
      .load(load_ok_c), .load_val(load_sec), .value(seconds), .wrap_c(sec_wrap_c)
   );

   mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
      .clk(clk), .rst_n(rst_n), .step(sec_wrap_c), .dir(dir_c),
      .load(load_ok_c), .load_val(load_min), .value(minutes), .wrap_c(min_wrap_c)
   );

   mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
      .clk(clk), .rst_n(rst_n), .step(min_wrap_c), .dir(dir_c),
      .load(load_ok_c), .load_val(load_hr), .value(hours), .wrap_c(hr_wrap_c)
   );

   always_comb begin
      tick_minute_d = sec_wrap_c;
      tick_hour_d   = min_wrap_c;
      tick_day_d    = hr_wrap_c;
      load_err_d    = load && !load_ok_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_minute_q <= 1'b0;
         tick_hour_q   <= 1'b0;
         tick_day_q    <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         tick_minute_q <= tick_minute_d;
         tick_hour_q   <= tick_hour_d;
         tick_day_q    <= tick_day_d;
         load_err_q    <= load_err_d;
      end
   end

   assign tick_minute = tick_minute_q;
   assign tick_hour   = tick_hour_q;
   assign tick_day    = tick_day_q;
   assign load_err    = load_err_q;

endmodule
